imgproc_msg_arbiter: RTL

//  Shares the single 32-bit image-processing message FIFO among N_REQ per-colour detection record writers.

---
 rtl/imgproc_msg_arbiter_pkg.sv | 28 ++
 rtl/imgproc_msg_arbiter_if.sv | 16 +
 rtl/imgproc_rr_pick.sv | 30 +++
 rtl/imgproc_msg_arbiter.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/imgproc_msg_arbiter_pkg.sv
// Shared definitions for the image-processing message arbiter.
//   MSG_WORDS   : words per message (header, word A, word B)
//   state_t     : arbiter FSM states
//   MSG_TAG_DEF : default header tag ("BBX")
//   msg_t       : payload captured at grant time
//   make_header : builds {tag, 5'b0, idx}
package imgproc_msg_arbiter_pkg;

  localparam int          MSG_WORDS   = 3;
  localparam logic [23:0] MSG_TAG_DEF = 24'h424258;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_WA   = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } msg_t;

  function automatic logic [31:0] make_header(input logic [23:0] tag, input logic [2:0] idx);
    return {tag, 5'b0, idx};
  endfunction

endpackage

// File: rtl/imgproc_msg_arbiter_if.sv
// Write-side bus of the shared message FIFO.
//   fifo_wrreq : write strobe (arbiter -> FIFO)
//   fifo_data  : write data   (arbiter -> FIFO)
//   fifo_flush : FIFO is being cleared this cycle (FIFO side -> arbiter)
//   fifo_usedw : FIFO occupancy in words (FIFO -> arbiter)
interface imgproc_msg_arbiter_if #(
  parameter int USEDW_W = 8
);
  logic               fifo_wrreq;
  logic [31:0]        fifo_data;
  logic               fifo_flush;
  logic [USEDW_W-1:0] fifo_usedw;

  modport master (output fifo_wrreq, fifo_data, input  fifo_flush, fifo_usedw);
  modport slave  (input  fifo_wrreq, fifo_data, output fifo_flush, fifo_usedw);
endinterface

// File: rtl/imgproc_rr_pick.sv
// Combinational rotate-priority picker.
//   req    : pending requests
//   rr_ptr : index searched first; search continues rr_ptr+1, ... mod N_REQ
//   valid  : at least one request pending
//   idx    : first pending index found in that order
module imgproc_rr_pick #(
  parameter int N_REQ = 5
) (
  input  logic [N_REQ-1:0] req,
  input  logic [2:0]       rr_ptr,
  output logic             valid,
  output logic [2:0]       idx
);

  logic [2:0] j;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    j     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = 3'((int'(rr_ptr) + k) % N_REQ);
      if (!valid && req[j]) begin
        valid = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/imgproc_msg_arbiter.sv
// Round-robin arbiter sharing one 32-bit message FIFO among N_REQ detection
// record writers. Each grant emits header, word A, word B on consecutive
// cycles, and is only made when the FIFO can hold the whole message.
//   clk, reset_n : clock, synchronous active-low reset
//   req          : per-requester pending message (level, held until ack)
//   payload_a/b  : words A/B, requester i at [32i+31:32i]
//   ack          : one-cycle pulse, payload of requester i captured
//   enable       : allows new grants
//   fifo         : FIFO write bus (wrreq/data out, flush/usedw in)
//   busy         : message in progress
//   grant_idx    : last granted requester
//   stall_count  : saturating count of idle cycles blocked by FIFO space
module imgproc_msg_arbiter
  import imgproc_msg_arbiter_pkg::*;
#(
  parameter int          N_REQ      = 5,
  parameter int          FIFO_DEPTH = 256,
  parameter int          USEDW_W    = 8,
  parameter logic [23:0] MSG_TAG    = MSG_TAG_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*32-1:0]  payload_a,
  input  logic [N_REQ*32-1:0]  payload_b,
  output logic [N_REQ-1:0]     ack,
  input  logic                 enable,
  imgproc_msg_arbiter_if.master fifo,
  output logic                 busy,
  output logic [2:0]           grant_idx,
  output logic [15:0]          stall_count
);

  // One spare word beyond the message keeps usedw from wrapping to 0 at full.
  localparam logic [USEDW_W:0] SPACE_MAX = (USEDW_W+1)'(FIFO_DEPTH - MSG_WORDS - 1);

  state_t            state_q, state_d;
  logic [2:0]        rr_q, rr_d;
  logic [N_REQ-1:0]  ack_d;
  logic              wr_q, wr_d;
  logic [31:0]       data_q, data_d;
  logic [2:0]        gidx_d;
  logic [15:0]       stall_d;
  msg_t              cap_q, cap_d;

  logic              pick_vld;
  logic [2:0]        pick_idx;
  logic              space_ok, want;
  logic [31:0]       pa_arr [N_REQ];
  logic [31:0]       pb_arr [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign pa_arr[i] = payload_a[32*i +: 32];
    assign pb_arr[i] = payload_b[32*i +: 32];
  end

  imgproc_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (req),
    .rr_ptr (rr_q),
    .valid  (pick_vld),
    .idx    (pick_idx)
  );

  assign space_ok = ({1'b0, fifo.fifo_usedw} <= SPACE_MAX);
  assign want     = enable & pick_vld & ~fifo.fifo_flush;

  // wr_d/data_d describe the word on the bus during the *next* cycle, so the
  // header goes out the cycle after the grant with no extra latency.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    ack_d   = '0;
    wr_d    = 1'b0;
    data_d  = data_q;
    gidx_d  = grant_idx;
    stall_d = stall_count;
    cap_d   = cap_q;
    case (state_q)
      ST_IDLE: begin
        if (want) begin
          if (space_ok) begin
            state_d = ST_HDR;
            ack_d   = N_REQ'(1) << pick_idx;
            gidx_d  = pick_idx;
            rr_d    = 3'((int'(pick_idx) + 1) % N_REQ);
            cap_d.a = pa_arr[pick_idx];
            cap_d.b = pb_arr[pick_idx];
            wr_d    = 1'b1;
            data_d  = make_header(MSG_TAG, pick_idx);
          end else if (stall_count != 16'hFFFF) begin
            stall_d = stall_count + 16'd1;
          end
        end
      end
      ST_HDR: begin
        state_d = ST_WA;
        wr_d    = 1'b1;
        data_d  = cap_q.a;
      end
      ST_WA: begin
        state_d = ST_WB;
        wr_d    = 1'b1;
        data_d  = cap_q.b;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A flush drops whatever is left of the message; the requester stays served.
    if (fifo.fifo_flush) begin
      state_d = ST_IDLE;
      wr_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      ack         <= '0;
      wr_q        <= 1'b0;
      data_q      <= '0;
      busy        <= 1'b0;
      grant_idx   <= '0;
      stall_count <= '0;
      cap_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      ack         <= ack_d;
      wr_q        <= wr_d;
      data_q      <= data_d;
      busy        <= (state_d != ST_IDLE);
      grant_idx   <= gidx_d;
      stall_count <= stall_d;
      cap_q       <= cap_d;
    end
  end

  assign fifo.fifo_wrreq = wr_q;
  assign fifo.fifo_data  = data_q;

endmodule
